// File: rtl/bk_multiword_adder.sv
`default_nettype none
// ============================================================================
// Module   : bk_multiword_adder
// Purpose  : Sequential wide adder, one 16-bit slice per cycle, LS slice first,
//            with valid/ready handshakes on operands and result.
//            Optional subtract mode enabled by macro BK_MULTIWORD_SUB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bk_multiword_adder #(
    parameter int WORDS   = 4,
    parameter int SLICE_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SLICE_W*WORDS-1:0] in_a,
    input  logic [SLICE_W*WORDS-1:0] in_b,
`ifdef BK_MULTIWORD_SUB_EN
    input  logic                     op_sub,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SLICE_W*WORDS-1:0] out_sum,
    output logic                     out_cout,
    output logic                     busy
);

    localparam int c_W     = SLICE_W * WORDS;
    localparam int c_IDX_W = (WORDS > 2) ? $clog2(WORDS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(WORDS - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_carry;
    logic [c_W-1:0]     r_a;
    logic [c_W-1:0]     r_b;
    logic [c_W-1:0]     r_sum;
    logic               r_cout;
`ifdef BK_MULTIWORD_SUB_EN
    logic               r_sub;
`endif

    logic [SLICE_W-1:0] w_a_slice;
    logic [SLICE_W-1:0] w_b_slice;
    logic [SLICE_W:0]   w_slice_sum;

    always_comb begin
        w_a_slice = r_a[r_idx*SLICE_W +: SLICE_W];
`ifdef BK_MULTIWORD_SUB_EN
        // Subtraction as A + ~B + 1; the +1 comes from the initial carry.
        w_b_slice = r_b[r_idx*SLICE_W +: SLICE_W] ^ {SLICE_W{r_sub}};
`else
        w_b_slice = r_b[r_idx*SLICE_W +: SLICE_W];
`endif
        w_slice_sum = {1'b0, w_a_slice} + {1'b0, w_b_slice} + {{SLICE_W{1'b0}}, r_carry};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
`ifdef BK_MULTIWORD_SUB_EN
            r_sub   <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_idx   <= '0;
                        r_sum   <= '0;
`ifdef BK_MULTIWORD_SUB_EN
                        r_sub   <= op_sub;
                        r_carry <= op_sub;
`else
                        r_carry <= 1'b0;
`endif
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_sum[r_idx*SLICE_W +: SLICE_W] <= w_slice_sum[SLICE_W-1:0];
                    r_carry <= w_slice_sum[SLICE_W];
                    if (r_idx == c_LAST) begin
                        r_cout  <= w_slice_sum[SLICE_W];
                        r_state <= c_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = (r_state == c_DONE);
    assign busy      = (r_state == c_RUN);
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_bk_multiword_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bk_multiword_adder
// Purpose  : Directed self-checking bench for bk_multiword_adder (WORDS=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bk_multiword_adder;

    localparam int c_WORDS = 4;
    localparam int c_W     = 16 * c_WORDS;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [c_W-1:0] in_a;
    logic [c_W-1:0] in_b;
`ifdef BK_MULTIWORD_SUB_EN
    logic           op_sub;
`endif
    logic           out_valid;
    logic           out_ready;
    logic [c_W-1:0] out_sum;
    logic           out_cout;
    logic           busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    bk_multiword_adder #(.WORDS(c_WORDS), .SLICE_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
`ifdef BK_MULTIWORD_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [c_W-1:0] obs, input logic [c_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction; operands are scrambled after accept to prove capture.
    task automatic do_op(input string tag, input logic [c_W-1:0] a, input logic [c_W-1:0] b,
                         input logic [c_W-1:0] es, input logic ec, input int hold);
        int  lat;
        logic stable;
        @(negedge clk);
        in_a = a; in_b = b; in_valid = 1'b1;
        check({tag, "_rdy"}, c_W'(in_ready), c_W'(1));
        @(negedge clk);
        in_valid = 1'b0; in_a = ~a; in_b = a ^ b;
        check({tag, "_busy"}, c_W'(busy), c_W'(1));
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, c_W'(lat), c_W'(c_WORDS));
        check({tag, "_sum"}, out_sum, es);
        check({tag, "_cout"}, c_W'(out_cout), c_W'(ec));
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_sum !== es || out_cout !== ec || in_ready !== 1'b0)
                stable = 1'b0;
        end
        check({tag, "_hold"}, c_W'(stable), c_W'(1));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ov_clr"}, c_W'(out_valid), c_W'(0));
        check({tag, "_rdy_back"}, c_W'(in_ready), c_W'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   t1;
        int   t2;
        int   k;
        logic quiet;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
`ifdef BK_MULTIWORD_SUB_EN
        op_sub = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", c_W'(in_ready), c_W'(1));
        check("rst_out_valid", c_W'(out_valid), c_W'(0));
        check("rst_sum", out_sum, '0);
        check("rst_cout", c_W'(out_cout), c_W'(0));
        check("rst_busy", c_W'(busy), c_W'(0));

        // Idle inputs ignored
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        check("idle_ready", c_W'(in_ready), c_W'(1));
        check("idle_ov", c_W'(out_valid), c_W'(0));

        do_op("small", 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002,
              64'h0000_0000_0000_0003, 1'b0, 0);
        do_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001,
              64'h0000_0000_0000_0000, 1'b1, 0);
        do_op("bp", 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111,
              64'h2345_6789_ABCD_F001, 1'b0, 10);
        do_op("midcarry", 64'h0000_0000_FFFF_0000, 64'h0000_0000_0001_0000,
              64'h0000_0001_0000_0000, 1'b0, 1);
        do_op("msb_ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
              64'h0000_0000_0000_0000, 1'b1, 0);

        // Reset at index 2 of RUN
        @(negedge clk);
        in_a = 64'hAAAA_BBBB_CCCC_DDDD; in_b = 64'h1111_2222_3333_4444; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_ov", c_W'(out_valid), c_W'(0));
        check("mrst_sum", out_sum, '0);
        check("mrst_rdy", c_W'(in_ready), c_W'(1));
        check("mrst_busy", c_W'(busy), c_W'(0));
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) quiet = 1'b0;
        end
        check("mrst_no_pulse", c_W'(quiet), c_W'(1));
        do_op("after_rst", 64'h0001_0002_0003_0004, 64'h0010_0020_0030_FFFC,
              64'h0011_0022_0034_0000, 1'b0, 0);

        // Back-to-back with in_valid held and out_ready tied high
        @(negedge clk);
        out_ready = 1'b1;
        in_a = 64'h0000_0000_0000_00FF; in_b = 64'h0000_0000_0000_0001; in_valid = 1'b1;
        t1 = cyc + 1;
        @(negedge clk);
        in_a = 64'hFFFF_0000_0000_0000; in_b = 64'h0001_0000_0000_0005;
        k = 0;
        while (out_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        check("b2b_sum1", out_sum, 64'h0000_0000_0000_0100);
        check("b2b_cout1", c_W'(out_cout), c_W'(0));
        k = 0;
        while (in_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        t2 = cyc + 1;
        check("b2b_spacing", c_W'(t2 - t1), c_W'(6));
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (out_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        check("b2b_sum2", out_sum, 64'h0000_0000_0000_0005);
        check("b2b_cout2", c_W'(out_cout), c_W'(1));
        @(negedge clk);
        out_ready = 1'b0;

`ifdef BK_MULTIWORD_SUB_EN
        op_sub = 1'b1;
        do_op("sub_neg", 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 0);
        do_op("sub_pos", 64'd7, 64'd5, 64'd2, 1'b1, 0);
        op_sub = 1'b0;
        do_op("sub_off", 64'd7, 64'd5, 64'd12, 1'b0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
